// File: rtl/count_bcd_monitor.sv
// count_bcd_monitor: BCD conversion, window check and lap tally for the 10..40 counter.
// Latency: BCD digits 9 edges after the capture edge; wrap pulses, lap_count and range_err 1 edge.
// Backpressure: none. count is sampled every cycle; changes during a conversion are
//               picked up after it finishes, so only the settled value is guaranteed.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   count      8-bit counter value, valid every cycle
//   load       counter load strobe, used only to mask wraps caused by a load
//   bcd_hund   hundreds digit (0..2) of the last converted value
//   bcd_tens   tens digit
//   bcd_ones   ones digit
//   bcd_valid  one-cycle pulse when the BCD digits update
//   wrap_up    one-cycle pulse on a natural HI -> LO step
//   wrap_dn    one-cycle pulse on a natural LO -> HI step
//   lap_count  up-wraps minus down-wraps, modulo 256
//   range_err  count was outside LO..HI on the previous edge
module count_bcd_monitor #(
    parameter logic [7:0] LO = 8'd10,
    parameter logic [7:0] HI = 8'd40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       load,
    output logic [1:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       bcd_valid,
    output logic       wrap_up,
    output logic       wrap_dn,
    output logic [7:0] lap_count,
    output logic       range_err
);

    // Converter states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    // Shift register layout: [19:16] hundreds, [15:12] tens, [11:8] ones,
    // [7:0] binary value still being shifted out.
    logic [19:0] shreg_q,    shreg_d;
    logic [2:0]  iter_q,     iter_d;
    logic [7:0]  last_cnt_q, last_cnt_d;
    logic        primed_q,   primed_d;

    logic [1:0]  hund_q,     hund_d;
    logic [3:0]  tens_q,     tens_d;
    logic [3:0]  ones_q,     ones_d;
    logic        valid_q,    valid_d;

    logic [7:0]  prev_q,     prev_d;
    logic        load_q,     load_d;
    logic        wrap_up_q,  wrap_up_d;
    logic        wrap_dn_q,  wrap_dn_d;
    logic [7:0]  lap_q,      lap_d;
    logic        range_q,    range_d;

    // ------------------------------------------------------------------
    // One double-dabble iteration: correct every BCD nibble that would
    // overflow past 9 once doubled, then shift the whole register left.
    // ------------------------------------------------------------------
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5) begin
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        iter_d     = iter_q;
        last_cnt_d = last_cnt_q;
        primed_d   = primed_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The first edge after reset always converts, even if
                // count happens to equal the cleared last_cnt.
                if (!primed_q || (count != last_cnt_q)) begin
                    shreg_d    = {12'b0, count};
                    last_cnt_d = count;
                    primed_d   = 1'b1;
                    iter_d     = 3'd0;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                shreg_d = dd_step(shreg_q);
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // 8-bit input tops out at 255, so only two hundreds bits matter.
                hund_d  = shreg_q[17:16];
                tens_d  = shreg_q[15:12];
                ones_d  = shreg_q[11:8];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wrap detection, lap tally, range flag
    // ------------------------------------------------------------------
    always_comb begin
        prev_d    = count;
        load_d    = load;
        // load_q masks the edge right after a load: the counter jumped
        // because it was loaded, not because it counted through a bound.
        wrap_up_d = (prev_q == HI) && (count == LO) && !load_q;
        wrap_dn_d = (prev_q == LO) && (count == HI) && !load_q;
        lap_d     = lap_q;
        if (wrap_up_d) begin
            lap_d = lap_q + 8'd1;
        end else if (wrap_dn_d) begin
            lap_d = lap_q - 8'd1;
        end
        range_d   = (count < LO) || (count > HI);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            iter_q     <= '0;
            last_cnt_q <= '0;
            primed_q   <= 1'b0;
            hund_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            valid_q    <= 1'b0;
            prev_q     <= '0;
            load_q     <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            lap_q      <= '0;
            range_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            iter_q     <= iter_d;
            last_cnt_q <= last_cnt_d;
            primed_q   <= primed_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
            prev_q     <= prev_d;
            load_q     <= load_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            lap_q      <= lap_d;
            range_q    <= range_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bcd_hund  = hund_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign bcd_valid = valid_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_dn   = wrap_dn_q;
    assign lap_count = lap_q;
    assign range_err = range_q;

endmodule

// File: tb/tb_count_bcd_monitor.sv
module tb_count_bcd_monitor;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] count = 8'd0;
    logic       load  = 1'b0;
    logic [1:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       bcd_valid;
    logic       wrap_up;
    logic       wrap_dn;
    logic [7:0] lap_count;
    logic       range_err;

    int n_tests = 0;
    int n_fail  = 0;

    count_bcd_monitor #(.LO(8'd10), .HI(8'd40)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .load      (load),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .bcd_valid (bcd_valid),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .lap_count (lap_count),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled just after the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps until bcd_valid is seen; returns the number of edges taken, or -1 on timeout.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (bcd_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic chk_bcd(input string tag, input int h, input int t, input int o);
        chk({tag, "_hund"}, 32'(bcd_hund), 32'(h));
        chk({tag, "_tens"}, 32'(bcd_tens), 32'(t));
        chk({tag, "_ones"}, 32'(bcd_ones), 32'(o));
    endtask

    int lat;
    int pulses;
    logic [7:0] rvals [4] = '{8'd9, 8'd10, 8'd40, 8'd41};
    logic       rexp  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // ---------------- reset ----------------
        step(2);
        chk("rst_valid", 32'(bcd_valid), 0);
        chk("rst_range", 32'(range_err), 0);
        chk("rst_lap",   32'(lap_count), 0);
        chk("rst_wrap",  32'({wrap_up, wrap_dn}), 0);
        chk_bcd("rst", 0, 0, 0);

        // First edge after release captures count=0.
        rst = 1'b1;
        step(1);
        chk("range_after_first_edge", 32'(range_err), 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bcd_valid === 1'b1) pulses++;
        end
        chk("no_early_valid", 32'(pulses), 0);
        step(1);
        chk("first_valid_at_E9", 32'(bcd_valid), 1);
        chk_bcd("zero", 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bcd_valid === 1'b1) pulses++;
        end
        chk("no_repeat_pulse", 32'(pulses), 0);

        // ---------------- 37 then 200 ----------------
        count = 8'd37;
        wait_valid(30, lat);
        chk("lat_37", 32'(lat), 10);
        chk_bcd("v37", 0, 3, 7);
        chk("range_37", 32'(range_err), 0);
        step(1);
        chk("valid_one_cycle", 32'(bcd_valid), 0);
        count = 8'd200;
        wait_valid(30, lat);
        chk("lat_200", 32'(lat), 10);
        chk_bcd("v200", 2, 0, 0);
        chk("range_200", 32'(range_err), 1);

        // ---------------- natural up-wrap ----------------
        count = 8'd39; step(1);
        chk("up_pre39", 32'(wrap_up), 0);
        count = 8'd40; step(1);
        chk("up_pre40", 32'(wrap_up), 0);
        chk("lap_pre_up", 32'(lap_count), 0);
        count = 8'd10; step(1);
        chk("wrap_up_pulse", 32'(wrap_up), 1);
        chk("wrap_dn_quiet", 32'(wrap_dn), 0);
        chk("lap_after_up", 32'(lap_count), 1);
        step(1);
        chk("wrap_up_clear", 32'(wrap_up), 0);
        chk("lap_hold_up", 32'(lap_count), 1);

        // ---------------- down-wrap from lap 0, then 255 -> 0 ----------------
        rst = 1'b0; count = 8'd11; step(1);
        chk("lap_reset", 32'(lap_count), 0);
        rst = 1'b1; step(1);
        count = 8'd10; step(1);
        chk("dn_pre10", 32'(wrap_dn), 0);
        count = 8'd40; step(1);
        chk("wrap_dn_pulse", 32'(wrap_dn), 1);
        chk("wrap_up_quiet", 32'(wrap_up), 0);
        chk("lap_255", 32'(lap_count), 255);
        step(1);
        chk("wrap_dn_clear", 32'(wrap_dn), 0);
        chk("lap_hold_255", 32'(lap_count), 255);
        count = 8'd10; step(1);
        chk("wrap_up_rollover", 32'(wrap_up), 1);
        chk("lap_rollover_0", 32'(lap_count), 0);

        // ---------------- load suppresses wrap ----------------
        count = 8'd20; step(1);
        count = 8'd40; step(1);
        load = 1'b1; step(1);
        chk("load_edge_wrap", 32'({wrap_up, wrap_dn}), 0);
        count = 8'd10; load = 1'b0; step(1);
        chk("load_no_wrap_up", 32'(wrap_up), 0);
        chk("load_no_wrap_dn", 32'(wrap_dn), 0);
        chk("load_lap_same", 32'(lap_count), 0);
        step(1);
        chk("load_no_wrap_late", 32'(wrap_up), 0);

        // ---------------- range boundaries ----------------
        for (int i = 0; i < 4; i++) begin
            count = rvals[i];
            step(1);
            chk($sformatf("range_%0d", rvals[i]), 32'(range_err), 32'(rexp[i]));
        end

        // ---------------- change during CONV ----------------
        step(25);
        count = 8'd25; step(1);
        step(3);
        count = 8'd26;
        wait_valid(30, lat);
        chk("lat_25_rest", 32'(lat), 6);
        chk_bcd("v25", 0, 2, 5);
        wait_valid(30, lat);
        chk("lat_26_requeue", 32'(lat), 10);
        chk_bcd("v26", 0, 2, 6);

        // ---------------- reset mid-CONV ----------------
        count = 8'd150; step(1);
        step(3);
        rst = 1'b0; step(1);
        chk_bcd("midrst", 0, 0, 0);
        chk("midrst_valid", 32'(bcd_valid), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bcd_valid === 1'b1) pulses++;
        end
        chk("midrst_no_valid", 32'(pulses), 0);
        rst = 1'b1;
        wait_valid(30, lat);
        chk("lat_after_rst", 32'(lat), 10);
        chk_bcd("v150", 1, 5, 0);

        // ---------------- top of range ----------------
        count = 8'd255;
        wait_valid(30, lat);
        chk_bcd("v255", 2, 5, 5);
        count = 8'd99;
        wait_valid(30, lat);
        chk_bcd("v99", 0, 9, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
